// File: rtl/adder_mul_sqrt_2_pkg.sv
// Shared definitions for the sqrt(2) scaling butterflies: coefficient, FSM encoding
// and the round/saturate helper also used by the div_sqrt_2 family.
package adder_mul_sqrt_2_pkg;

  localparam int DATA_N    = 3;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // floor(sqrt(2) * 2**frac) by bitwise integer square root of 2 * 4**frac (frac <= 29).
  function automatic longint unsigned sqrt2_fixed(input int frac);
    longint unsigned x;
    longint unsigned r;
    longint unsigned t;
    x = 64'd2 << (2 * frac);
    r = 64'd0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  localparam logic [FRAC_BITS:0] SQRT2_FRAC = (FRAC_BITS + 1)'(sqrt2_fixed(FRAC_BITS));

  // Round half up at the binary point, then clamp into a w-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/adder_mul_sqrt_2_mul_sqrt_2_serial.sv
// One serial shift-add multiplier by sqrt(2): consumes one coefficient bit per step,
// MSB first, and registers the rounded/saturated result on the final step.
module mul_sqrt_2_serial
  import adder_mul_sqrt_2_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 8,
  parameter int CW   = $clog2(FRAC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                last,
  input  logic [CW-1:0]       cnt,
  input  logic signed [W:0]   operand,
  output logic signed [W-1:0] result
);

  localparam int ACC_W = W + FRAC + 2;
  localparam logic [FRAC:0] K = (FRAC + 1)'(sqrt2_fixed(FRAC));

  logic signed [W:0]       op_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] op_ext;
  logic signed [ACC_W-1:0] acc_next;

  // The final step's partial product is folded in before rounding, so the
  // result register sees the complete product in the same edge.
  always_comb begin
    op_ext   = {{(ACC_W - W - 1){op_q[W]}}, op_q};
    acc_next = acc_q;
    if (K[cnt]) acc_next = acc_q + (op_ext <<< cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      acc_q  <= '0;
      result <= '0;
    end else if (load) begin
      op_q  <= operand;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      if (last) begin
        result <= W'(round_sat({{(64 - ACC_W){acc_next[ACC_W-1]}}, acc_next}, FRAC, W));
      end
    end
  end

endmodule

// File: rtl/adder_mul_sqrt_2.sv
// Inverse-scaling FFT butterfly: (a+b)*sqrt(2) and (a-b)*sqrt(2), computed serially
// with a valid/ready handshake on both sides.
module adder_mul_sqrt_2
  import adder_mul_sqrt_2_pkg::*;
#(
  parameter int N    = DATA_N,
  parameter int FRAC = FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [2**N-1:0]   in_1,
  input  logic signed [2**N-1:0]   in_2,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [2**N-1:0]   add_sqrt_2,
  output logic signed [2**N-1:0]   sub_sqrt_2,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(FRAC + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and results stay
  // stable in DONE until out_ready is seen high.
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          load;
  logic          step;
  logic          last;
  logic signed [W:0] sum;
  logic signed [W:0] diff;

  assign sum  = {in_1[W-1], in_1} + {in_2[W-1], in_2};
  assign diff = {in_1[W-1], in_1} - {in_2[W-1], in_2};

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) cnt_q <= CW'(FRAC);
      else if (step && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  mul_sqrt_2_serial #(.W(W), .FRAC(FRAC), .CW(CW)) u_sum (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .last    (last),
    .cnt     (cnt_q),
    .operand (sum),
    .result  (add_sqrt_2)
  );

  mul_sqrt_2_serial #(.W(W), .FRAC(FRAC), .CW(CW)) u_diff (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .last    (last),
    .cnt     (cnt_q),
    .operand (diff),
    .result  (sub_sqrt_2)
  );

endmodule
